remote_cmd_sender: RTL and testbench

Host-side command transmitter for the Knight's Tour remote link. It accepts a 16-bit command from the bench or host logic and sends it as two bytes, high byte first, over a byte-level UART transmitter handshake. It then waits for the robot's single response byte (positive acknowledge 0xA5 or otherwise) and reports it, or reports a timeout. It sits directly upstream of the robot's UART receive path, between the command source and the UART tx/rx cores.

---
 rtl/remote_cmd_sender.sv | 110 +++++++++++
 tb/tb_remote_cmd_sender.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/remote_cmd_sender.sv
// Host-side command transmitter: sends a 16-bit command as two UART bytes (high first),
// then waits for a single response byte or a timeout.
module remote_cmd_sender #(
  parameter int         TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0] ACK_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        cmd_sent,
  output logic        resp_rdy,
  output logic [7:0]  resp,
  output logic        resp_ack,
  output logic        timeout,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {IDLE, TX_HI, WAIT_HI, TX_LO, WAIT_LO, WAIT_RESP} state_t;

  state_t        state, state_n;
  logic [15:0]   cmd_buf, cmd_buf_n;
  logic [CW-1:0] resp_cnt, resp_cnt_n;
  logic [7:0]    tx_data_n, resp_n;
  logic          trmt_n, cmd_sent_n, resp_rdy_n, timeout_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cmd_buf  <= '0;
      resp_cnt <= '0;
      tx_data  <= '0;
      trmt     <= 1'b0;
      cmd_sent <= 1'b0;
      resp_rdy <= 1'b0;
      resp     <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      cmd_buf  <= cmd_buf_n;
      resp_cnt <= resp_cnt_n;
      tx_data  <= tx_data_n;
      trmt     <= trmt_n;
      cmd_sent <= cmd_sent_n;
      resp_rdy <= resp_rdy_n;
      resp     <= resp_n;
      timeout  <= timeout_n;
    end
  end

  // Next values of every registered output are decoded here so each one is a clean flop.
  always_comb begin
    state_n    = state;
    cmd_buf_n  = cmd_buf;
    resp_cnt_n = resp_cnt;
    tx_data_n  = tx_data;
    trmt_n     = 1'b0;
    cmd_sent_n = 1'b0;
    resp_rdy_n = resp_rdy;
    resp_n     = resp;
    timeout_n  = 1'b0;
    unique case (state)
      IDLE: if (send_cmd) begin
        cmd_buf_n  = cmd;
        resp_rdy_n = 1'b0;
        trmt_n     = 1'b1;
        tx_data_n  = cmd[15:8];
        state_n    = TX_HI;
      end
      TX_HI: state_n = WAIT_HI;
      WAIT_HI: if (tx_done) begin
        trmt_n    = 1'b1;
        tx_data_n = cmd_buf[7:0];
        state_n   = TX_LO;
      end
      TX_LO: state_n = WAIT_LO;
      WAIT_LO: if (tx_done) begin
        cmd_sent_n = 1'b1;
        resp_cnt_n = '0;
        state_n    = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (resp_cnt != CNT_MAX) resp_cnt_n = resp_cnt + 1'b1;
        // A response on the terminal cycle takes priority over the timeout.
        if (rx_rdy) begin
          resp_n     = rx_data;
          resp_rdy_n = 1'b1;
          state_n    = IDLE;
        end else if (resp_cnt == CNT_LAST) begin
          timeout_n = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign resp_ack = resp_rdy && (resp == ACK_BYTE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_remote_cmd_sender.sv
// Directed self-checking bench for remote_cmd_sender (TIMEOUT_CYC = 50).
module tb_remote_cmd_sender;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd;
  logic        send_cmd, tx_done, rx_rdy;
  logic [7:0]  rx_data, tx_data, resp;
  logic        trmt, cmd_sent, resp_rdy, resp_ack, timeout, busy;

  int n_chk = 0, n_pass = 0;
  int trmt_cnt = 0, sent_cnt = 0, to_cnt = 0;
  logic [7:0] bytes_q[$];

  remote_cmd_sender #(.TIMEOUT_CYC(50), .ACK_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .send_cmd(send_cmd),
    .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
    .rx_rdy(rx_rdy), .rx_data(rx_data), .cmd_sent(cmd_sent),
    .resp_rdy(resp_rdy), .resp(resp), .resp_ack(resp_ack),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pre-edge values: each cycle counted once, at the edge that ends it.
  always @(posedge clk) begin
    if (trmt) begin
      trmt_cnt <= trmt_cnt + 1;
      bytes_q.push_back(tx_data);
    end
    if (cmd_sent) sent_cnt <= sent_cnt + 1;
    if (timeout)  to_cnt   <= to_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Accept cycle: trmt/busy high with the high byte in the next cycle.
  task automatic send(input logic [15:0] c);
    cmd = c; send_cmd = 1'b1;
    tick(1);
    send_cmd = 1'b0;
    chk("hi_trmt", 32'(trmt), 32'd1);
    chk("hi_busy", 32'(busy), 32'd1);
    chk("hi_byte", 32'(tx_data), 32'(c[15:8]));
  endtask

  task automatic finish_hi(input int dly, input logic [7:0] hi, input logic [7:0] lo);
    tick(dly);
    chk("hi_hold", 32'(tx_data), 32'(hi));
    tx_done = 1'b1; tick(1); tx_done = 1'b0;
    chk("lo_trmt", 32'(trmt), 32'd1);
    chk("lo_byte", 32'(tx_data), 32'(lo));
  endtask

  task automatic finish_lo(input int dly);
    tick(dly);
    tx_done = 1'b1; tick(1); tx_done = 1'b0;
    chk("cmd_sent", 32'(cmd_sent), 32'd1);
  endtask

  task automatic respond(input logic [7:0] b, input logic ack);
    rx_data = b; rx_rdy = 1'b1; tick(1); rx_rdy = 1'b0;
    chk("resp", 32'(resp), 32'(b));
    chk("resp_rdy", 32'(resp_rdy), 32'd1);
    chk("resp_ack", 32'(resp_ack), 32'(ack));
    chk("resp_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int t0, s0, b0;
    rst = 1'b1; cmd = '0; send_cmd = 1'b0; tx_done = 1'b0; rx_rdy = 1'b0; rx_data = '0;
    tick(3);
    chk("rst_outs", {tx_data, resp, 8'(trmt), 1'b0, cmd_sent, resp_rdy, resp_ack, timeout, busy},
        32'd0);
    rst = 1'b0;
    tick(2);

    // Basic ack
    t0 = trmt_cnt; s0 = sent_cnt; b0 = bytes_q.size();
    send(16'h0000);
    finish_hi(100, 8'h00, 8'h00);
    finish_lo(100);
    respond(8'hA5, 1'b1);
    tick(2);
    chk("basic_trmts", 32'(trmt_cnt - t0), 32'd2);
    chk("basic_sent", 32'(sent_cnt - s0), 32'd1);
    chk("basic_b0", 32'(bytes_q[b0]), 32'h00);
    chk("basic_b1", 32'(bytes_q[b0+1]), 32'h00);

    // Byte order and latching
    b0 = bytes_q.size();
    send(16'h2C46);
    cmd = 16'hFFFF;
    finish_hi(5, 8'h2C, 8'h46);
    finish_lo(5);
    respond(8'hA5, 1'b1);
    tick(2);
    chk("order_b0", 32'(bytes_q[b0]), 32'h2C);
    chk("order_b1", 32'(bytes_q[b0+1]), 32'h46);

    // Nack
    send(16'h1234);
    finish_hi(3, 8'h12, 8'h34);
    finish_lo(3);
    respond(8'h5A, 1'b0);
    tick(2);

    // Timeout; the accepting send also drops resp_rdy
    t0 = to_cnt;
    send(16'h0F0F);
    chk("send_clr_rdy", 32'(resp_rdy), 32'd0);
    finish_hi(2, 8'h0F, 8'h0F);
    finish_lo(2);
    tick(49);
    chk("to_early", 32'(timeout), 32'd0);
    chk("to_busy_early", 32'(busy), 32'd1);
    tick(1);
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_rdy", 32'(resp_rdy), 32'd0);
    rx_data = 8'h11; rx_rdy = 1'b1; tick(1); rx_rdy = 1'b0;
    chk("to_once", 32'(timeout), 32'd0);
    chk("stray_resp", 32'(resp), 32'h5A);
    chk("stray_rdy", 32'(resp_rdy), 32'd0);
    tick(2);
    chk("to_count", 32'(to_cnt - t0), 32'd1);

    // Ignored send_cmd in WAIT_HI and rx_rdy in WAIT_LO
    t0 = trmt_cnt; b0 = bytes_q.size();
    send(16'hBEEF);
    tick(2);
    cmd = 16'h1111; send_cmd = 1'b1; tick(1); send_cmd = 1'b0;
    finish_hi(2, 8'hBE, 8'hEF);
    tick(2);
    rx_data = 8'h77; rx_rdy = 1'b1; tick(1); rx_rdy = 1'b0;
    chk("ign_resp", 32'(resp), 32'h5A);
    chk("ign_rdy", 32'(resp_rdy), 32'd0);
    finish_lo(2);
    respond(8'hA5, 1'b1);
    tick(3);
    chk("ign_trmts", 32'(trmt_cnt - t0), 32'd2);
    chk("ign_b1", 32'(bytes_q[b0+1]), 32'hEF);

    // Reset in WAIT_LO
    s0 = sent_cnt;
    send(16'hCAFE);
    finish_hi(2, 8'hCA, 8'hFE);
    tick(2);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("mid_rst_outs", {tx_data, resp, 8'(trmt), 1'b0, cmd_sent, resp_rdy, resp_ack, timeout, busy},
        32'd0);
    t0 = trmt_cnt;
    tick(2);
    tx_done = 1'b1; tick(1); tx_done = 1'b0;
    tick(3);
    chk("rst_no_sent", 32'(sent_cnt - s0), 32'd0);
    chk("rst_no_trmt", 32'(trmt_cnt - t0), 32'd0);
    send(16'h0102);
    finish_hi(4, 8'h01, 8'h02);
    finish_lo(4);
    respond(8'hA5, 1'b1);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
